// File: rtl/multicycle_decoder.sv
// Moore control FSM for the multicycle ARM datapath. It sequences each instruction and drives the per-state enables and selects.
// Optional branch-with-link support is built when the BL_EN macro is defined.
module multicycle_decoder #(
    parameter int ALUCTRL_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    output logic [3:0]           state,
    output logic [1:0]           FlagW,
    output logic                 PCS,
    output logic                 NextPC,
    output logic                 RegW,
    output logic                 MemW,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic                 ALUSrcA,
    output logic                 NoWrite,
    output logic                 Shift,
    output logic                 LinkSel,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
`ifdef BL_EN
        BRANCH = 4'd9,
        BLINK  = 4'd10
`else
        BRANCH = 4'd9
`endif
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MOV = 3'b100;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] alu_code;

    logic [2:0] dp_code;
    logic       dp_nowrite;
    logic       dp_shift;
    logic       dp_arith;
    logic       dp_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Data-processing decode on Funct[4:1]; unknown codes become a flagless NOP.
    always_comb begin
        dp_code    = ALU_ADD;
        dp_nowrite = 1'b0;
        dp_shift   = 1'b0;
        dp_arith   = 1'b0;
        dp_valid   = 1'b1;
        case (Funct[4:1])
            4'b0100: begin dp_code = ALU_ADD; dp_arith = 1'b1; end
            4'b0010: begin dp_code = ALU_SUB; dp_arith = 1'b1; end
            4'b0000: dp_code = ALU_AND;
            4'b1100: dp_code = ALU_ORR;
            4'b1010: begin
                dp_code    = ALU_SUB;
                dp_arith   = 1'b1;
                dp_nowrite = 1'b1;
            end
            4'b1101: begin dp_code = ALU_MOV; dp_shift = 1'b1; end
            default: begin
                dp_code    = ALU_ADD;
                dp_nowrite = 1'b1;
                dp_valid   = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d   = FETCH;
        FlagW     = 2'b00;
        PCS       = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        NoWrite   = 1'b0;
        Shift     = 1'b0;
        LinkSel   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcB   = 2'b00;
        alu_code  = ALU_ADD;
        case (state_q)
            FETCH: begin
                state_d   = DECODE;
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b01: state_d = MEMADR;
                    2'b00: state_d = Funct[5] ? EXECI : EXECR;
`ifdef BL_EN
                    2'b10: state_d = Funct[4] ? BLINK : BRANCH;
`else
                    2'b10: state_d = BRANCH;
`endif
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                state_d = Funct[0] ? MEMRD : MEMWR;
                ALUSrcB = 2'b01;
            end
            MEMRD: begin
                state_d = MEMWB;
                AdrSrc  = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                PCS       = (Rd == 4'b1111);
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECR, EXECI: begin
                state_d  = dp_nowrite ? FETCH : ALUWB;
                ALUSrcB  = (state_q == EXECI) ? 2'b01 : 2'b00;
                alu_code = dp_code;
                NoWrite  = dp_nowrite;
                Shift    = dp_shift;
                FlagW    = dp_valid ? {Funct[0], Funct[0] & dp_arith} : 2'b00;
            end
            ALUWB: begin
                RegW = 1'b1;
                PCS  = (Rd == 4'b1111);
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCS       = 1'b1;
            end
`ifdef BL_EN
            BLINK: begin
                state_d = BRANCH;
                RegW    = 1'b1;
                LinkSel = 1'b1;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    assign state      = state_q;
    assign ImmSrc     = Op;
    assign RegSrc     = {(Op == 2'b01) & ~Funct[0], (Op == 2'b10)};
    assign ALUControl = ALUCTRL_W'(alu_code);

endmodule

// File: tb/tb_multicycle_decoder.sv
// Directed test of multicycle_decoder: state sequences and per-state outputs for each instruction class.
// Expectations for the branch-with-link path follow the BL_EN macro.
module tb_multicycle_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] state;
    logic [1:0] FlagW;
    logic       PCS, NextPC, RegW, MemW, IRWrite;
    logic       AdrSrc, ALUSrcA, NoWrite, Shift, LinkSel;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0] ALUControl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_decoder #(.ALUCTRL_W(3)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .state(state), .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC),
        .RegW(RegW), .MemW(MemW), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .NoWrite(NoWrite), .Shift(Shift),
        .LinkSel(LinkSel), .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd);
        Op = op;
        Funct = fn;
        Rd = rd;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        Op = 2'b00; Funct = '0; Rd = '0;
        tick();
        chk("reset_state", 8'(state), 8'd0);
        reset = 1'b0;

        // LDR interrupted by reset in MEMRD
        instr(2'b01, 6'b011001, 4'b0011);
        tick(); tick(); tick();
        chk("ldr_pre_reset_state", 8'(state), 8'd3);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_irwrite", 8'(IRWrite), 8'd1);
        chk("rst_nextpc", 8'(NextPC), 8'd1);
        chk("rst_regw", 8'(RegW), 8'd0);
        chk("rst_memw", 8'(MemW), 8'd0);

        // ADD immediate
        instr(2'b00, 6'b101001, 4'b0010);
        chk("add_fetch_srcb", 8'(ALUSrcB), 8'd2);
        chk("add_fetch_res", 8'(ResultSrc), 8'd2);
        chk("add_fetch_srca", 8'(ALUSrcA), 8'd1);
        tick(); chk("add_s1", 8'(state), 8'd1);
        tick(); chk("add_s7", 8'(state), 8'd7);
        chk("add_alu", 8'(ALUControl), 8'd0);
        chk("add_flagw", 8'(FlagW), 8'd3);
        chk("add_srcb", 8'(ALUSrcB), 8'd1);
        chk("add_regw_exec", 8'(RegW), 8'd0);
        tick(); chk("add_s8", 8'(state), 8'd8);
        chk("add_regw", 8'(RegW), 8'd1);
        chk("add_pcs", 8'(PCS), 8'd0);
        tick(); chk("add_s0", 8'(state), 8'd0);

        // CMP register
        instr(2'b00, 6'b010101, 4'b0000);
        tick(); tick(); chk("cmp_s6", 8'(state), 8'd6);
        chk("cmp_alu", 8'(ALUControl), 8'd1);
        chk("cmp_nowrite", 8'(NoWrite), 8'd1);
        chk("cmp_flagw", 8'(FlagW), 8'd3);
        chk("cmp_srcb", 8'(ALUSrcB), 8'd0);
        chk("cmp_regw", 8'(RegW), 8'd0);
        tick(); chk("cmp_s0", 8'(state), 8'd0);
        chk("cmp_regw_end", 8'(RegW), 8'd0);

        // MOV/LSL to PC
        instr(2'b00, 6'b011010, 4'b1111);
        tick(); tick(); chk("mov_s6", 8'(state), 8'd6);
        chk("mov_shift", 8'(Shift), 8'd1);
        chk("mov_alu", 8'(ALUControl), 8'd4);
        chk("mov_flagw", 8'(FlagW), 8'd0);
        tick(); chk("mov_s8", 8'(state), 8'd8);
        chk("mov_pcs", 8'(PCS), 8'd1);
        chk("mov_regw", 8'(RegW), 8'd1);
        chk("mov_shift_wb", 8'(Shift), 8'd0);
        tick(); chk("mov_s0", 8'(state), 8'd0);

        // SUB immediate with S
        instr(2'b00, 6'b100101, 4'b0001);
        tick(); tick(); chk("sub_s7", 8'(state), 8'd7);
        chk("sub_alu", 8'(ALUControl), 8'd1);
        chk("sub_flagw", 8'(FlagW), 8'd3);
        tick(); tick(); chk("sub_s0", 8'(state), 8'd0);

        // AND with S: logical ops update NZ only
        instr(2'b00, 6'b000001, 4'b0001);
        tick(); tick(); chk("and_alu", 8'(ALUControl), 8'd2);
        chk("and_flagw", 8'(FlagW), 8'd2);
        tick(); tick();

        // ORR register
        instr(2'b00, 6'b011000, 4'b0001);
        tick(); tick(); chk("orr_alu", 8'(ALUControl), 8'd3);
        chk("orr_nowrite", 8'(NoWrite), 8'd0);
        tick(); tick();

        // unimplemented DP code behaves as NOP
        instr(2'b00, 6'b000111, 4'b0001);
        tick(); tick(); chk("nop_s6", 8'(state), 8'd6);
        chk("nop_nowrite", 8'(NoWrite), 8'd1);
        chk("nop_flagw", 8'(FlagW), 8'd0);
        chk("nop_alu", 8'(ALUControl), 8'd0);
        tick(); chk("nop_s0", 8'(state), 8'd0);

        // LDR
        instr(2'b01, 6'b011001, 4'b0100);
        chk("ldr_immsrc", 8'(ImmSrc), 8'd1);
        chk("ldr_regsrc", 8'(RegSrc), 8'd0);
        tick(); chk("ldr_s1", 8'(state), 8'd1);
        tick(); chk("ldr_s2", 8'(state), 8'd2);
        chk("ldr_srcb", 8'(ALUSrcB), 8'd1);
        tick(); chk("ldr_s3", 8'(state), 8'd3);
        chk("ldr_adrsrc", 8'(AdrSrc), 8'd1);
        chk("ldr_memw3", 8'(MemW), 8'd0);
        tick(); chk("ldr_s4", 8'(state), 8'd4);
        chk("ldr_res", 8'(ResultSrc), 8'd1);
        chk("ldr_regw", 8'(RegW), 8'd1);
        chk("ldr_memw4", 8'(MemW), 8'd0);
        chk("ldr_pcs", 8'(PCS), 8'd0);
        tick(); chk("ldr_s0", 8'(state), 8'd0);

        // STR
        instr(2'b01, 6'b011000, 4'b0100);
        chk("str_regsrc", 8'(RegSrc), 8'd2);
        chk("str_memw0", 8'(MemW), 8'd0);
        tick(); chk("str_memw1", 8'(MemW), 8'd0);
        tick(); chk("str_s2", 8'(state), 8'd2);
        chk("str_memw2", 8'(MemW), 8'd0);
        tick(); chk("str_s5", 8'(state), 8'd5);
        chk("str_memw5", 8'(MemW), 8'd1);
        chk("str_adrsrc", 8'(AdrSrc), 8'd1);
        chk("str_regsrc_end", 8'(RegSrc), 8'd2);
        tick(); chk("str_s0", 8'(state), 8'd0);
        chk("str_memw_end", 8'(MemW), 8'd0);

        // BL
        instr(2'b10, 6'b010000, 4'b0000);
        chk("bl_immsrc", 8'(ImmSrc), 8'd2);
        chk("bl_regsrc", 8'(RegSrc), 8'd1);
        tick(); chk("bl_s1", 8'(state), 8'd1);
        tick();
`ifdef BL_EN
        chk("bl_s10", 8'(state), 8'd10);
        chk("bl_linksel", 8'(LinkSel), 8'd1);
        chk("bl_regw", 8'(RegW), 8'd1);
        tick();
`endif
        chk("bl_s9", 8'(state), 8'd9);
        chk("bl_pcs", 8'(PCS), 8'd1);
        chk("bl_srcb", 8'(ALUSrcB), 8'd1);
        chk("bl_res", 8'(ResultSrc), 8'd2);
        chk("bl_linksel9", 8'(LinkSel), 8'd0);
        tick(); chk("bl_s0", 8'(state), 8'd0);

        // Op=11: two-cycle no-op
        instr(2'b11, 6'b111111, 4'b1111);
        tick(); chk("op3_s1", 8'(state), 8'd1);
        chk("op3_regw", 8'(RegW), 8'd0);
        chk("op3_memw", 8'(MemW), 8'd0);
        chk("op3_pcs", 8'(PCS), 8'd0);
        tick(); chk("op3_s0", 8'(state), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_decoder.md
# multicycle_decoder

Control-unit decoder for the multicycle ARM processor: a Moore state machine that sequences each instruction over 3–5 cycles and emits datapath enables/selects per state. It sits between the instruction register (Op/Funct/Rd, held stable after FETCH) and the conditional-logic block, which gates PCS/RegW/MemW with CondEx. Adds MOV/shift, CMP, a parametrised ALU-control width and optional branch-with-link.

## Interface
- ALUCTRL_W, 3, ALUControl width; legal ≥3; upper bits beyond [2:0] driven 0
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- Op  in  2  instr[27:26]
- Funct  in  6  instr[25:20]
- Rd  in  4  instr[15:12]
- state  out  4  current state encoding (debug)
- FlagW  out  2  [1]=NZ write, [0]=CV write
- PCS, NextPC, RegW, MemW, IRWrite  out  1 each  raw enables (not condition-gated)
- AdrSrc, ALUSrcA, NoWrite, Shift, LinkSel  out  1 each  datapath selects/qualifiers
- ResultSrc, ALUSrcB, ImmSrc, RegSrc  out  2 each  datapath selects
- ALUControl  out  ALUCTRL_W  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MOV/shift

## Operation
- States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, BLINK=10.
- Transitions: FETCH→DECODE; DECODE→ Op=01: MEMADR; Op=00: Funct[5]? EXECI : EXECR; Op=10: BRANCH (BLINK if BL_EN and Funct[4]); Op=11: FETCH. MEMADR→ Funct[0]? MEMRD : MEMWR; MEMRD→MEMWB; MEMWB, MEMWR, ALUWB, BRANCH→FETCH; EXECR/EXECI→ NoWrite? FETCH : ALUWB; BLINK→BRANCH.
- Per-state outputs (unlisted = 0):
  - FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU ADD.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU ADD.
  - MEMADR: ALUSrcB=01, ALU ADD. MEMRD/MEMWR: AdrSrc=1 (MEMWR also MemW=1). MEMWB: ResultSrc=01, RegW=1.
  - EXECR: ALUSrcB=00; EXECI: ALUSrcB=01; both use DP ALU decode.
  - ALUWB: RegW=1. BRANCH: ALUSrcB=01, ResultSrc=10, ALU ADD, PCS=1. BLINK: RegW=1, LinkSel=1.
- DP ALU decode on Funct[4:1] (EXECR/EXECI only): 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 SUB+NoWrite (CMP), 1101 code 100+Shift=1 (MOV/LSL). Any other code: ALUControl=0, NoWrite=1 (executes as NOP, no register write, no flags).
- FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ADD|SUB); FlagW=00 outside EXECR/EXECI and for unimplemented codes.
- PCS additionally =1 in MEMWB and ALUWB when Rd=1111.
- ImmSrc = Op; RegSrc[0]=(Op==10); RegSrc[1]=(Op==01 & ~Funct[0]); held through all states of the instruction.

## Timing
- State register updates on rising clk; all outputs are combinational from state plus IR fields (no extra latency).
- Reset: state=FETCH on the next edge; outputs then equal FETCH values. Reset mid-instruction aborts it; no enable from the aborted state is asserted after the reset edge.
- Cycles per instruction: DP 4, CMP 3, LDR 5, STR 4, B 3, BL 4, Op=11 2.
- Op/Funct/Rd must be stable from DECODE to instruction end (IRWrite only in FETCH).

## Configuration
- BL_EN defined: Op=10 with Funct[4]=1 goes DECODE→BLINK→BRANCH; BLINK asserts RegW and LinkSel (datapath writes PC+4 to R14).
- BL_EN undefined: BLINK state not built; BL executes as B; LinkSel tied 0.

## Test plan
- reset high 2 cycles mid-LDR → state=0, IRWrite=1, NextPC=1, RegW=MemW=0 on the first post-reset cycle.
- ADD imm (Op=00, Funct=101001, Rd=0010) → states 0,1,7,8; ALUControl=000, FlagW=11 in EXECI, RegW=1 in ALUWB, PCS=0.
- CMP reg (Op=00, Funct=010101) → states 0,1,6,0; ALUControl=001, NoWrite=1, FlagW=11, RegW never 1.
- MOV/LSL (Funct=011010) → Shift=1, ALUControl=100, FlagW=00; with Rd=1111 → PCS=1 in ALUWB.
- LDR (Op=01, Funct=011001) → 0,1,2,3,4, MemW=0, ResultSrc=01 in MEMWB; STR (Funct=011000) → 0,1,2,5, MemW=1 only in state 5.
- BL (Op=10, Funct=010000) → with BL_EN 0,1,10,9 (LinkSel=1 in 10); without BL_EN 0,1,9; Op=11 → 0,1,0 with no writes.
